primitive_core_mc: RTL and testbench

Parametrised multi-cycle successor of the primitive single-cycle device. Fetches 32-bit instructions from an external instruction memory over a request/ready handshake, and executes them with an internal 32-entry register file and ALU. Adds start/step control, a switch-input writeback source, a hard-wired zero register, halt detection, a retired-instruction counter and a debug register read port. Sits between the board-level top (switches, HEX display) and an instruction ROM/RAM.

---
 rtl/primitive_core_mc.sv | 142 ++++++++++++++
 tb/tb_primitive_core_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/primitive_core_mc.sv
// Multi-cycle core: fetches 32-bit instructions over a req/ready handshake and executes them
// against a 32-entry register file with a hard-wired zero register.
module primitive_core_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             step_mode_i,
  input  logic [XLEN-1:0]  sw_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_ready_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic [4:0]       dbg_sel_i,
  output logic [XLEN-1:0]  dbg_reg_o,
  output logic [PC_W-1:0]  pc_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic              halted;
  logic              req;
  logic [CNT_W-1:0]  retired;
  logic [XLEN-1:0]   rf [32];

  logic              br_jump, br_cond, wr_en;
  logic [1:0]        wb_sel;
  logic [3:0]        alu_op;
  logic [4:0]        ra1, ra2, wa;
  logic [7:0]        imm;

  assign {br_jump, br_cond, wr_en, wb_sel, alu_op, ra1, ra2, wa, imm} = ir;

  logic [XLEN-1:0]   op_a, op_b, alu_res, const_se, wb_data;
  logic [ShW-1:0]    shamt;
  logic              flag, take, is_halt;
  logic [PC_W-1:0]   pc_off, next_pc;

  assign op_a     = (ra1 == 5'd0) ? '0 : rf[ra1];
  assign op_b     = (ra2 == 5'd0) ? '0 : rf[ra2];
  assign shamt    = op_b[ShW-1:0];
  assign const_se = XLEN'($signed(imm));
  assign pc_off   = PC_W'($signed(imm));

  always_comb begin
    alu_res = '0;
    flag    = 1'b0;
    unique case (alu_op)
      4'b0000: alu_res = op_a + op_b;
      4'b1000: alu_res = op_a - op_b;
      4'b0001: alu_res = op_a << shamt;
      4'b0101: alu_res = op_a >> shamt;
      4'b1101: alu_res = $unsigned($signed(op_a) >>> shamt);
      4'b0010: alu_res = XLEN'($signed(op_a) < $signed(op_b));
      4'b0011: alu_res = XLEN'(op_a < op_b);
      4'b0100: alu_res = op_a ^ op_b;
      4'b0110: alu_res = op_a | op_b;
      4'b0111: alu_res = op_a & op_b;
      // Compare ops only drive the branch flag; their result stays 0.
      4'b1100: flag = (op_a == op_b);
      4'b1001: flag = (op_a != op_b);
      4'b1010: flag = ($signed(op_a) < $signed(op_b));
      4'b1011: flag = ($signed(op_a) >= $signed(op_b));
      4'b1110: flag = (op_a < op_b);
      4'b1111: flag = (op_a >= op_b);
      default: ;
    endcase
  end

  always_comb begin
    unique case (wb_sel)
      2'b01:   wb_data = sw_i;
      2'b10:   wb_data = alu_res;
      default: wb_data = const_se;
    endcase
  end

  assign take    = br_jump | (br_cond & flag);
  assign next_pc = take ? pc + pc_off : pc + PC_W'(4);
  assign is_halt = br_jump && (imm == 8'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= StIdle;
      pc      <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      req     <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (en_i && !halted) begin
            state <= StFetch;
            req   <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ready_i) begin
            ir    <= imem_rdata_i;
            state <= StExec;
            req   <= 1'b0;
          end
        end
        StExec: begin
          if (wr_en && (wa != 5'd0)) rf[wa] <= wb_data;
          pc      <= next_pc;
          retired <= retired + 1'b1;
          if (is_halt) begin
            halted <= 1'b1;
            state  <= StIdle;
          end else if (!step_mode_i && en_i) begin
            state <= StFetch;
            req   <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign halted_o    = halted;
  assign retired_o   = retired;
  assign dbg_reg_o   = (dbg_sel_i == 5'd0) ? '0 : rf[dbg_sel_i];

endmodule

// File: tb/tb_primitive_core_mc.sv
// Bench for primitive_core_mc: step-mode instruction table checked through a scoreboard,
// then hand-written handshake, throughput, reset, wrap and halt sequences.
module tb_primitive_core_mc;

  logic        clk = 1'b0;
  logic        rst, en, step_mode, imem_req, imem_ready, halted;
  logic [31:0] sw, imem_rdata, dbg_reg;
  logic [9:0]  imem_addr, pc;
  logic [4:0]  dbg_sel;
  logic [15:0] retired;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];

  primitive_core_mc dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .step_mode_i  (step_mode),
    .sw_i         (sw),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .dbg_sel_i    (dbg_sel),
    .dbg_reg_o    (dbg_reg),
    .pc_o         (pc),
    .halted_o     (halted),
    .retired_o    (retired)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] instr;
    logic [4:0]  sel;
    logic [31:0] exp_reg;
    logic [9:0]  exp_pc;
  } vec_t;

  vec_t vecs [18];
  vec_t exp_q [$];

  function automatic logic [31:0] enc(input logic b, input logic c, input logic we,
                                      input logic [1:0] ws, input logic [3:0] op,
                                      input logic [4:0] ra1, input logic [4:0] ra2,
                                      input logic [4:0] wa, input logic [7:0] k);
    return {b, c, we, ws, op, ra1, ra2, wa, k};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One en_i pulse in step mode, then wait (bounded) for the instruction to retire.
  task automatic do_step(output bit ok);
    logic [15:0] prev;
    prev = retired;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (retired != prev) break;
      @(negedge clk);
    end
    ok = (retired != prev);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: got retired 0x%0h expected change", retired);
    end
  endtask

  initial begin
    bit   ok;
    vec_t v;

    vecs[0]  = '{10'h00, enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 1, 8'h85), 5'd1, 32'hFFFF_FF85, 10'h04};
    vecs[1]  = '{10'h04, enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 1, 8'h05), 5'd1, 32'd5, 10'h08};
    vecs[2]  = '{10'h08, enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 2, 8'h07), 5'd2, 32'd7, 10'h0C};
    vecs[3]  = '{10'h0C, enc(0, 0, 1, 2'b10, 4'b0000, 1, 2, 3, 8'h00), 5'd3, 32'd12, 10'h10};
    vecs[4]  = '{10'h10, enc(0, 0, 1, 2'b10, 4'b1000, 1, 2, 4, 8'h00), 5'd4, 32'hFFFF_FFFE, 10'h14};
    vecs[5]  = '{10'h14, enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 0, 8'h33), 5'd0, 32'd0, 10'h18};
    vecs[6]  = '{10'h18, enc(0, 0, 1, 2'b01, 4'b0000, 0, 0, 5, 8'h00), 5'd5, 32'hA5A5_1234, 10'h1C};
    vecs[7]  = '{10'h1C, enc(0, 0, 1, 2'b10, 4'b0001, 2, 1, 6, 8'h00), 5'd6, 32'h0000_00E0, 10'h20};
    vecs[8]  = '{10'h20, enc(0, 0, 1, 2'b10, 4'b0101, 4, 1, 7, 8'h00), 5'd7, 32'h07FF_FFFF, 10'h24};
    vecs[9]  = '{10'h24, enc(0, 0, 1, 2'b10, 4'b0010, 4, 1, 8, 8'h00), 5'd8, 32'd1, 10'h28};
    vecs[10] = '{10'h28, enc(0, 0, 1, 2'b10, 4'b0011, 1, 4, 9, 8'h00), 5'd9, 32'd1, 10'h2C};
    vecs[11] = '{10'h2C, enc(0, 1, 0, 2'b00, 4'b1001, 1, 2, 0, 8'h08), 5'd3, 32'd12, 10'h34};
    vecs[12] = '{10'h34, enc(0, 1, 1, 2'b10, 4'b1100, 1, 2, 13, 8'h08), 5'd13, 32'd0, 10'h38};
    vecs[13] = '{10'h38, enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 2, 8'h05), 5'd2, 32'd5, 10'h3C};
    vecs[14] = '{10'h3C, enc(0, 1, 0, 2'b00, 4'b1100, 1, 2, 0, 8'h0C), 5'd1, 32'd5, 10'h48};
    vecs[15] = '{10'h48, enc(0, 1, 0, 2'b00, 4'b1111, 4, 1, 0, 8'hF8), 5'd4, 32'hFFFF_FFFE, 10'h40};
    vecs[16] = '{10'h40, enc(0, 0, 1, 2'b10, 4'b0111, 3, 4, 11, 8'h00), 5'd11, 32'd12, 10'h44};
    vecs[17] = '{10'h44, enc(0, 0, 1, 2'b10, 4'b0110, 1, 3, 12, 8'h00), 5'd12, 32'd13, 10'h48};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 18; i++) mem[vecs[i].addr[9:2]] = vecs[i].instr;

    rst = 1'b1; en = 1'b0; step_mode = 1'b1; sw = 32'hA5A5_1234;
    imem_ready = 1'b1; dbg_sel = 5'd1;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {22'd0, pc}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_r1", dbg_reg, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Step-mode table through the scoreboard.
    for (int i = 0; i < 18; i++) begin
      dbg_sel = vecs[i].sel;
      exp_q.push_back(vecs[i]);
      do_step(ok);
      v = exp_q.pop_front();
      if (ok) begin
        chk($sformatf("v%0d_reg", i), dbg_reg, v.exp_reg);
        chk($sformatf("v%0d_pc", i), {22'd0, pc}, {22'd0, v.exp_pc});
        chk($sformatf("v%0d_retired", i), {16'd0, retired}, i + 1);
        chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 32'd0);
      end
    end

    // Fetch stall: request and address must hold while ready is low.
    step_mode = 1'b0; imem_ready = 1'b0; en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", {22'd0, imem_addr}, 32'h48);
      chk("stall_retired", {16'd0, retired}, 32'd18);
      @(negedge clk);
    end
    en = 1'b0; imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_done_pc", {22'd0, pc}, 32'h40);
    chk("stall_done_retired", {16'd0, retired}, 32'd19);

    // Free-run: three instructions in six cycles after leaving IDLE.
    dbg_sel = 5'd11; en = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("run_retired", {16'd0, retired}, 32'd22);
    chk("run_pc", {22'd0, pc}, 32'h40);
    chk("run_req", {31'd0, imem_req}, 32'd0);
    chk("run_r11", dbg_reg, 32'd12);

    // Reset in the middle of a stalled fetch, with ready coincident.
    imem_ready = 1'b0; en = 1'b1; dbg_sel = 5'd1;
    repeat (2) @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc", {22'd0, pc}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired}, 32'd0);
    chk("mid_rst_r1", dbg_reg, 32'd0);
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd0);

    // Backward jump from PC 0 wraps to the top of the address space.
    mem[0] = enc(1, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 8'hFC);
    step_mode = 1'b1;
    do_step(ok);
    chk("wrap_pc", {22'd0, pc}, 32'h3FC);
    chk("wrap_retired", {16'd0, retired}, 32'd1);

    // Jump-to-self halts after retiring, with its write honoured.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem[0] = enc(0, 0, 1, 2'b00, 4'b0000, 0, 0, 1, 8'h11);
    mem[1] = enc(1, 0, 1, 2'b01, 4'b0000, 0, 0, 2, 8'h00);
    step_mode = 1'b0; en = 1'b1; dbg_sel = 5'd2;
    for (int n = 0; n < 30; n++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {22'd0, pc}, 32'h04);
    chk("halt_retired", {16'd0, retired}, 32'd2);
    chk("halt_r2", dbg_reg, 32'hA5A5_1234);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
      chk("halt_hold_retired", {16'd0, retired}, 32'd2);
    end
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
